adder_subtractor: RTL and testbench

Registered two's-complement adder/subtractor with a selectable operation, carry/borrow flag and signed-overflow flag. Operands `a` and `b` are added (`add_sub`=0) or `b` is subtracted from `a` (`add_sub`=1) using one shared ripple-carry chain with `b` conditionally inverted. The result is captured in output registers one clock after a valid input. The block is a small datapath leaf used wherever a narrow ALU add/sub slice is needed; the default width is 2 bits.

---
 rtl/adder_subtractor.sv | 72 +++++++
 tb/tb_adder_subtractor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/adder_subtractor.sv
// ---------------------------------------------------------------------------
// adder_subtractor
//
// Registered two's-complement adder/subtractor. One shared ripple-carry chain
// computes a+b (add_sub=0) or a-b (add_sub=1) by inverting b and injecting a
// carry-in of 1. Results are captured one clock after a valid input.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous, active-high reset (clears all outputs at once)
//   a          first operand / minuend
//   b          second operand / subtrahend
//   add_sub    0: a+b, 1: a-b
//   valid_in   qualifies a, b, add_sub on this clock edge
//   o          registered result, low WIDTH bits (wraps, never saturates)
//   c          registered carry-out of the MSB stage (subtract: 1 = no borrow)
//   v          registered signed-overflow flag
//   valid_out  one-cycle pulse when o/c/v hold a new result
//
// Handshake: valid_in is sampled on each rising edge; there is no ready, the
// block accepts one operation per clock. valid_out is high for exactly the
// cycle after each accepted operation. With valid_in low, o/c/v hold.
// ---------------------------------------------------------------------------
module adder_subtractor #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  input  logic             valid_in,
  output logic [WIDTH-1:0] o,
  output logic             c,
  output logic             v,
  output logic             valid_out
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   k;

  // Ripple chain. Subtraction reuses the adder as a + ~b + 1.
  always_comb begin
    bx   = b ^ {WIDTH{add_sub}};
    s    = '0;
    k    = '0;
    k[0] = add_sub;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ bx[i] ^ k[i];
      k[i+1] = (a[i] & bx[i]) | (k[i] & (a[i] ^ bx[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o         <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        o <= s;
        c <= k[WIDTH];
        // Carry into and out of the sign bit disagree exactly on overflow.
        v <= k[WIDTH] ^ k[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// ---------------------------------------------------------------------------
// tb_adder_subtractor
//
// Directed + randomized bench for adder_subtractor (WIDTH=2). Expected
// results come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_adder_subtractor;

  localparam int W   = 2;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         add_sub;
  logic         valid_in;
  logic [W-1:0] o;
  logic         c;
  logic         v;
  logic         valid_out;

  int compared;
  int mismatched;

  // Expected output word after the next edge: {valid_out, o, c, v}
  logic [W+2:0] exp_q[$];

  // Model of the held output registers
  logic [W-1:0] m_o;
  logic         m_c;
  logic         m_v;

  adder_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .add_sub   (add_sub),
    .valid_in  (valid_in),
    .o         (o),
    .c         (c),
    .v         (v),
    .valid_out (valid_out)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int to_signed(input int u);
    return (u >= MOD / 2) ? u - MOD : u;
  endfunction

  task automatic ref_op(input int ua, input int ub, input logic op,
                        output logic [W-1:0] ro, output logic rc, output logic rv);
    int r;
    int sr;
    if (!op) begin
      r  = ua + ub;
      sr = to_signed(ua) + to_signed(ub);
      rc = (r >= MOD);
    end else begin
      r  = ua - ub + MOD;
      sr = to_signed(ua) - to_signed(ub);
      rc = (ua >= ub);
    end
    ro = W'(r % MOD);
    rv = (sr > MOD / 2 - 1) || (sr < -(MOD / 2));
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_pending();
    logic [W+2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("valid_out", int'(valid_out), int'(e[W+2]));
      cmp("o",         int'(o),         int'(e[W+1:2]));
      cmp("c",         int'(c),         int'(e[1]));
      cmp("v",         int'(v),         int'(e[0]));
    end
  endtask

  task automatic check_cleared(input string tag);
    cmp({tag, "_o"},         int'(o),         0);
    cmp({tag, "_c"},         int'(c),         0);
    cmp({tag, "_v"},         int'(v),         0);
    cmp({tag, "_valid_out"}, int'(valid_out), 0);
  endtask

  // ---------------- driver ----------------
  // At each falling edge: check the result of the previous rising edge,
  // then drive the next operation and queue its expected outcome.
  task automatic drive(input int ua, input int ub, input logic op, input logic vin);
    @(negedge clk);
    check_pending();
    a        = W'(ua);
    b        = W'(ub);
    add_sub  = op;
    valid_in = vin;
    if (vin) ref_op(ua, ub, op, m_o, m_c, m_v);
    exp_q.push_back({vin, m_o, m_c, m_v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    compared   = 0;
    mismatched = 0;
    m_o = '0; m_c = 1'b0; m_v = 1'b0;
    rst      = 1'b0;
    a        = W'($urandom_range(MOD - 1));
    b        = W'($urandom_range(MOD - 1));
    add_sub  = 1'(($urandom_range(1)));
    valid_in = 1'b1;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check_cleared("reset_async");
    @(negedge clk);
    @(negedge clk);
    check_cleared("reset_held");
    rst      = 1'b0;
    valid_in = 1'b0;

    // Directed add cases
    drive(0, 1, 1'b0, 1'b1);
    drive(3, 1, 1'b0, 1'b1);
    drive(1, 1, 1'b0, 1'b1);
    // Directed subtract cases
    drive(2, 1, 1'b1, 1'b1);
    drive(1, 2, 1'b1, 1'b1);
    drive(3, 3, 1'b1, 1'b1);

    // Exhaustive back-to-back sweep
    for (int op = 0; op < 2; op++)
      for (int ia = 0; ia < MOD; ia++)
        for (int ib = 0; ib < MOD; ib++)
          drive(ia, ib, 1'(op), 1'b1);

    // Random stream with sporadic idle cycles
    for (int n = 0; n < 60; n++)
      drive(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
            1'($urandom_range(1)), 1'($urandom_range(3) != 0));

    // Hold: valid_in low for 3 cycles while inputs change
    drive(2, 3, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++)
      drive(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
            1'($urandom_range(1)), 1'b0);

    // Reset mid-stream, asserted between edges
    drive(3, 2, 1'b0, 1'b1);
    @(posedge clk);
    #1 check_pending();
    #1 rst = 1'b1;
    #1 check_cleared("reset_midstream");
    exp_q.delete();
    m_o = '0; m_c = 1'b0; m_v = 1'b0;

    // rst dominates valid_in across an edge
    a = 2'd3; b = 2'd3; add_sub = 1'b0; valid_in = 1'b1;
    @(negedge clk);
    check_cleared("reset_dominates");
    rst      = 1'b0;
    valid_in = 1'b0;

    // First result after reset
    drive(1, 3, 1'b1, 1'b1);
    drive(2, 2, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check_pending();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
